// File: rtl/mux_scan_controller.sv
// Loopback driver/checker for a 4:1 mux: drives a latched word onto the mux inputs,
// walks the select lines I0..I3, samples the mux output per address and flags readback mismatches.
module mux_scan_controller #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] data_in,
    output logic [3:0] mux_in,
    output logic       addr0,
    output logic       addr1,
    input  logic       mux_out,
    output logic       sample,
    output logic       serial_out,
    output logic       serial_valid,
    output logic [3:0] readback,
    output logic       busy,
    output logic       done,
    output logic       mismatch
);

    // Handshake: start is taken on a rising edge only while busy is low; it is never queued.
    // serial_valid is a one-cycle strobe qualifying serial_out; done is a one-cycle strobe
    // after which readback and mismatch are stable until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [1:0] idx;
    logic [3:0] rb_nxt;

    always_comb begin
        state_nxt   = state;
        sample      = 1'b0;
        rb_nxt      = readback;
        rb_nxt[idx] = mux_out;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                sample = (cnt == 4'(SETTLE - 1));
                if (sample && idx == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The address is only meaningful while scanning; it parks at 00 otherwise.
    assign addr0 = (state == SCAN) & idx[0];
    assign addr1 = (state == SCAN) & idx[1];
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx          <= 2'd0;
            mux_in       <= 4'd0;
            readback     <= 4'd0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            state        <= state_nxt;
            serial_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mux_in   <= data_in;
                        readback <= 4'd0;
                        mismatch <= 1'b0;
                        idx      <= 2'd0;
                        cnt      <= 4'd0;
                    end
                end
                SCAN: begin
                    if (sample) begin
                        readback     <= rb_nxt;
                        serial_out   <= mux_out;
                        serial_valid <= 1'b1;
                        cnt          <= 4'd0;
                        // Final capture: compare the fully assembled word on the way into DONE.
                        if (idx != 2'd3) idx <= idx + 2'd1;
                        else             mismatch <= (rb_nxt != mux_in);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller: ideal mux models around a SETTLE=2 and a SETTLE=1
// instance, with fault forcing, mid-scan start, and mid-scan reset scenarios.
module tb_mux_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       force0;

    logic       start2, start1;
    logic [3:0] data2, data1;
    logic [3:0] mux_in2, mux_in1, readback2, readback1;
    logic       addr0_2, addr1_2, addr0_1, addr1_1;
    logic       mux_out2, mux_out1;
    logic       sample2, sample1, sout2, sout1, svalid2, svalid1;
    logic       busy2, busy1, done2, done1, mism2, mism1;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt;

    always #5 clk = ~clk;

    assign mux_out2 = force0 ? 1'b0 : mux_in2[{addr1_2, addr0_2}];
    assign mux_out1 = mux_in1[{addr1_1, addr0_1}];

    mux_scan_controller #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2),
        .mux_in(mux_in2), .addr0(addr0_2), .addr1(addr1_2), .mux_out(mux_out2),
        .sample(sample2), .serial_out(sout2), .serial_valid(svalid2),
        .readback(readback2), .busy(busy2), .done(done2), .mismatch(mism2)
    );

    mux_scan_controller #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1),
        .mux_in(mux_in1), .addr0(addr0_1), .addr1(addr1_1), .mux_out(mux_out1),
        .sample(sample1), .serial_out(sout1), .serial_valid(svalid1),
        .readback(readback1), .busy(busy1), .done(done1), .mismatch(mism1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero2(input string tag);
        chk({tag, " mux_in"}, mux_in2, 4'b0000);
        chk({tag, " addr"}, {2'b00, addr1_2, addr0_2}, 4'd0);
        chk({tag, " sample/serial"}, {1'b0, sample2, sout2, svalid2}, 4'd0);
        chk({tag, " readback"}, readback2, 4'b0000);
        chk({tag, " busy/done/mism"}, {1'b0, busy2, done2, mism2}, 4'd0);
    endtask

    // One full SETTLE=2 scan from IDLE; exp_rb is what an ideal or forced mux returns.
    task automatic scan2(input logic [3:0] d, input logic [3:0] exp_rb, input bit poke);
        start2 = 1'b1;
        data2  = d;
        step();
        start2   = 1'b0;
        data2    = ~d;
        done_cnt = 0;
        chk("accept mux_in", mux_in2, d);
        chk("accept clears readback", readback2, 4'b0000);
        chk("accept clears mismatch", {3'b0, mism2}, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            if (done2) done_cnt++;
            chk($sformatf("busy c%0d", c), {3'b0, busy2}, 4'd1);
            chk($sformatf("done c%0d", c), {3'b0, done2}, {3'b0, c == 9});
            chk($sformatf("mux_in hold c%0d", c), mux_in2, d);
            if (c <= 8) begin
                chk($sformatf("addr c%0d", c), {2'b00, addr1_2, addr0_2}, 4'((c - 1) / 2));
                chk($sformatf("sample c%0d", c), {3'b0, sample2}, {3'b0, (c % 2) == 0});
            end
            chk($sformatf("serial_valid c%0d", c), {3'b0, svalid2}, {3'b0, (c >= 3) && (c % 2 == 1)});
            if (c >= 3 && (c % 2 == 1))
                chk($sformatf("serial_out c%0d", c), {3'b0, sout2}, {3'b0, exp_rb[(c - 3) / 2]});
            if (c == 9) begin
                chk("readback at done", readback2, exp_rb);
                chk("mismatch at done", {3'b0, mism2}, {3'b0, exp_rb != d});
            end
            if (poke && c == 4) begin
                start2 = 1'b1;
                data2  = 4'b0110;
            end else begin
                start2 = 1'b0;
            end
            step();
        end
        for (int c = 10; c <= 12; c++) begin
            if (done2) done_cnt++;
            chk($sformatf("idle busy c%0d", c), {3'b0, busy2}, 4'd0);
            chk($sformatf("hold mux_in c%0d", c), mux_in2, d);
            chk($sformatf("hold readback c%0d", c), readback2, exp_rb);
            chk($sformatf("hold mismatch c%0d", c), {3'b0, mism2}, {3'b0, exp_rb != d});
            step();
        end
        chk("done pulse count", 4'(done_cnt), 4'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        force0 = 1'b0;
        start2 = 1'b1;
        data2  = 4'b1111;
        start1 = 1'b0;
        data1  = 4'b0000;

        // Reset with start held high is ignored.
        step();
        step();
        chk_zero2("reset");
        start2 = 1'b0;
        rst_n  = 1'b1;
        step();
        step();
        chk("post-reset busy", {3'b0, busy2}, 4'd0);
        chk("post-reset mux_in", mux_in2, 4'b0000);

        // Ideal mux, 1010.
        scan2(4'b1010, 4'b1010, 1'b0);

        // Stuck-at-0 mux output on 1111.
        force0 = 1'b1;
        scan2(4'b1111, 4'b0000, 1'b0);
        force0 = 1'b0;

        // Start pulsed mid-scan is ignored; also confirms mismatch clears on next accept.
        scan2(4'b1010, 4'b1010, 1'b1);

        // Reset after the second capture of a 1100 scan.
        start2 = 1'b1;
        data2  = 4'b1100;
        step();
        start2   = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 4; c++) step();
        chk("pre-abort readback", readback2, 4'b0000);
        chk("pre-abort addr", {2'b00, addr1_2, addr0_2}, 4'd2);
        chk("pre-abort svalid", {3'b0, svalid2}, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero2("async abort");
        for (int c = 0; c < 6; c++) begin
            if (done2) done_cnt++;
            step();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (done2) done_cnt++;
            step();
        end
        chk("abort no done", 4'(done_cnt), 4'd0);
        chk_zero2("after abort idle");
        scan2(4'b0011, 4'b0011, 1'b0);

        // SETTLE=1 instance, 0001.
        start1 = 1'b1;
        data1  = 4'b0001;
        step();
        start1 = 1'b0;
        data1  = 4'b1110;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("s1 busy c%0d", c), {3'b0, busy1}, 4'd1);
            chk($sformatf("s1 done c%0d", c), {3'b0, done1}, {3'b0, c == 5});
            if (c <= 4) begin
                chk($sformatf("s1 addr c%0d", c), {2'b00, addr1_1, addr0_1}, 4'(c - 1));
                chk($sformatf("s1 sample c%0d", c), {3'b0, sample1}, 4'd1);
            end else begin
                chk("s1 sample c5", {3'b0, sample1}, 4'd0);
            end
            chk($sformatf("s1 serial_valid c%0d", c), {3'b0, svalid1}, {3'b0, c >= 2});
            if (c >= 2)
                chk($sformatf("s1 serial_out c%0d", c), {3'b0, sout1}, {3'b0, c == 2});
            if (c == 5) begin
                chk("s1 readback", readback1, 4'b0001);
                chk("s1 mismatch", {3'b0, mism1}, 4'd0);
            end
            step();
        end
        chk("s1 idle busy", {3'b0, busy1}, 4'd0);
        chk("s1 hold mux_in", mux_in1, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
- Upstream driver and readback checker for the 4:1 structural multiplexer (`addr0`, `addr1`, `in0`..`in3` -> `out`).
- Latches a 4-bit word and presents it on the mux data inputs. It then steps the select lines through I0, I1, I2, I3, holding each address for a settle window.
- At the end of each window it samples the mux output. It serializes the sampled bits and reassembles them into a readback word, then flags any mismatch against the driven word.
- Used as the self-checking harness around the gate-delay mux in hardware-style loopback tests.

Parameters:
- SETTLE, 2: clock cycles each address is held before `mux_out` is sampled. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to scan `data_in`. Accepted only when `busy`=0.
- data_in  input  4  word to drive. Bit k goes to mux input Ik.
- mux_in  output  4  latched word. Bit k drives mux input Ik.
- addr0  output  1  mux select LSB.
- addr1  output  1  mux select MSB.
- mux_out  input  1  multiplexer output.
- sample  output  1  high during the cycle whose closing edge captures `mux_out`.
- serial_out  output  1  last captured bit.
- serial_valid  output  1  one-cycle pulse accompanying each new `serial_out`.
- readback  output  4  captured bits. Bit k holds the value sampled at address k.
- busy  output  1  scan in progress, including the DONE cycle.
- done  output  1  one-cycle completion pulse.
- mismatch  output  1  `readback` != `mux_in`. Valid from `done` until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: `mux_in`, `addr0`, `addr1`, `sample`, `serial_out`, `serial_valid`, `readback`, `busy`, `done`, `mismatch`.
  - The internal settle counter `cnt` and index `idx` are cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On an edge with `start`=1, the block latches `data_in` into `mux_in`.
  - It also clears `readback` and `mismatch`, sets `idx`=0 and `cnt`=0, sets `busy`=1, and enters SCAN.
  - `addr1`/`addr0` = `idx[1]`/`idx[0]` throughout SCAN. The address is therefore 00 in the first SCAN cycle, and I0..I3 are visited in order.
- SCAN:
  - `cnt` increments each edge.
  - `sample` = (`cnt` == SETTLE-1), combinational from registered state.
  - On an edge with `sample`=1:
    - `readback[idx]` <= `mux_out`, `serial_out` <= `mux_out`, `serial_valid` <= 1 for the following cycle only.
    - `cnt` <= 0.
    - If `idx`<3, `idx` increments (the address changes on the same edge). If `idx`==3, go to DONE.
- DONE (exactly one cycle):
  - `done`=1, `busy`=1.
  - `mismatch` is registered on entry to DONE from the completed `readback` vs `mux_in` comparison, then held.
  - Next edge returns to IDLE with `busy`=0.
- Latency and holding:
  - Accepting edge E0. Captures occur at edges E0+SETTLE·k for k=1..4.
  - `done` is high between edges E0+4·SETTLE and E0+4·SETTLE+1.
  - `busy` is high for exactly 4·SETTLE+1 cycles.
  - The earliest next accept is edge E0+4·SETTLE+2.
- `start` while `busy`=1 (SCAN or DONE) is ignored. It is not queued, and `mux_in` does not change.
- `start` held high continuously starts back-to-back scans, each separated by one IDLE cycle.
- `mux_in`, `readback` and `mismatch` hold after DONE until the next accepted start.
- Reset mid-scan aborts immediately to the reset values. No `done` pulse is produced.
- `data_in` changes after the accept edge have no effect.

Test Plan:
- Reset with SETTLE=2 -> all outputs 0. `start`=1 asserted during reset is ignored. After release with `start`=0, `busy` stays 0.
- SETTLE=2, `data_in`=4'b1010, mux model ideal:
  - `addr` sequence 00,00,01,01,10,10,11,11.
  - `serial_out` pulses give 0,1,0,1.
  - `readback`=1010, `done` at cycle 9 after accept, `mismatch`=0, `busy` high for 9 cycles.
- SETTLE=1, `data_in`=4'b0001:
  - Addresses change every cycle.
  - `sample` is high for 4 consecutive cycles.
  - `readback`=0001, `done` at cycle 5.
- Fault injection: `mux_out` forced to 0 with `data_in`=4'b1111 -> `readback`=0000, `mismatch`=1, held until the next start.
- `start` pulsed mid-scan with `data_in`=4'b0110 during a 1010 scan -> ignored. `mux_in` stays 1010 and exactly one `done` pulse occurs.
- `rst_n` dropped after the second capture of a 1100 scan:
  - Outputs go to 0 asynchronously and no `done` pulse is produced.
  - A new `start` with `data_in`=4'b0011 completes normally with `readback`=0011.
